// File: rtl/tdc_pulse_gen.sv
// Start/stop pulse-pair generator for exercising a time-to-digital converter.
// Emits N pairs of W-cycle pulses, stop trailing start by D cycles, separated by GAP_CYCLES idle cycles.
module tdc_pulse_gen #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_delay,
    input  logic [3:0] cfg_width,
    input  logic [3:0] cfg_count,
    input  logic       abort,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy,
    output logic       done,
    output logic [4:0] pairs_sent
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PAIR = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [8:0] t_q, t_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] dly_q, dly_d;
    logic [3:0] wid_q, wid_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] pairs_q, pairs_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       done_q, done_d;

    logic       accept;
    logic       cancel;
    logic       pair_last;
    logic [4:0] pairs_inc;
    logic [8:0] stop_end_d;

    assign cfg_ready = (state_q == IDLE) && ena && !abort;
    assign accept    = cfg_valid && cfg_ready;
    assign cancel    = abort || !ena;
    assign pairs_inc = pairs_q + 5'd1;
    assign pair_last = (t_q == ({1'b0, dly_q} + {5'b0, wid_q} - 9'd1));

    always_comb begin
        // NOTE: every next-state signal takes a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        t_d     = t_q;
        gap_d   = gap_q;
        dly_d   = dly_q;
        wid_d   = wid_q;
        cnt_d   = cnt_q;
        pairs_d = pairs_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PAIR;
                    t_d     = 9'd0;
                    dly_d   = (cfg_delay == 8'd0) ? 8'd1 : cfg_delay;
                    wid_d   = (cfg_width == 4'd0) ? 4'd1 : cfg_width;
                    cnt_d   = (cfg_count == 4'd0) ? 5'd16 : {1'b0, cfg_count};
                    pairs_d = 5'd0;
                end
            end
            PAIR: begin
                if (cancel) begin
                    state_d = IDLE;
                    t_d     = 9'd0;
                end else if (pair_last) begin
                    pairs_d = pairs_inc;
                    t_d     = 9'd0;
                    if (pairs_inc == cnt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = 8'd0;
                    end
                end else begin
                    t_d = t_q + 9'd1;
                end
            end
            GAP: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = PAIR;
                    t_d     = 9'd0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = 9'd0;
            end
        endcase
    end

    // Pulses are decoded from next-state values so the output flops line up with t.
    assign stop_end_d = {1'b0, dly_d} + {5'b0, wid_d};

    always_comb begin
        start_d = (state_d == PAIR) && (t_d < {5'b0, wid_d});
        stop_d  = (state_d == PAIR) && (t_d >= {1'b0, dly_d}) && (t_d < stop_end_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= 9'd0;
            gap_q   <= 8'd0;
            dly_q   <= 8'd0;
            wid_q   <= 4'd0;
            cnt_q   <= 5'd0;
            pairs_q <= 5'd0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            gap_q   <= gap_d;
            dly_q   <= dly_d;
            wid_q   <= wid_d;
            cnt_q   <= cnt_d;
            pairs_q <= pairs_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign pairs_sent = pairs_q;

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Scoreboard bench for tdc_pulse_gen: stimulus pushes hand-computed sequence summaries,
// a negedge monitor measures each sequence (busy rise to busy fall) and compares.
module tb_tdc_pulse_gen;

    typedef struct {
        int first_start;
        int first_stop;
        int rises;
        int second_rise;
        int start_hi;
        int stop_hi;
        int both_hi;
        int done_cnt;
        int end_cyc;
        int pairs;
    } seq_t;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_delay;
    logic [3:0] cfg_width;
    logic [3:0] cfg_count;
    logic       abort;
    logic       start_o;
    logic       stop_o;
    logic       busy;
    logic       done;
    logic [4:0] pairs_sent;

    int n_checks = 0;
    int n_fail   = 0;

    seq_t exp_q[$];

    tdc_pulse_gen #(.GAP_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_count  (cfg_count),
        .abort      (abort),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy       (busy),
        .done       (done),
        .pairs_sent (pairs_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic seq_t mk(int fs, int fp, int rs, int sr, int sh, int ph, int bh,
                                int dc, int ec, int pr);
        seq_t s;
        s.first_start = fs; s.first_stop = fp; s.rises = rs; s.second_rise = sr;
        s.start_hi = sh; s.stop_hi = ph; s.both_hi = bh; s.done_cnt = dc;
        s.end_cyc = ec; s.pairs = pr;
        return s;
    endfunction

    // ---------------- monitor ----------------
    seq_t obs;
    bit   in_seq     = 0;
    bit   prev_busy  = 0;
    bit   prev_start = 0;
    int   cyc        = 0;
    int   seq_n      = 0;

    always @(negedge clk) begin
        seq_t e;
        if (rst) begin
            in_seq     = 0;
            prev_busy  = 0;
            prev_start = 0;
        end else begin
            if (!in_seq && done)
                check("stray_done", 1, 0);
            if (!prev_busy && busy) begin
                obs        = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                in_seq     = 1;
                cyc        = 0;
                prev_start = 0;
            end
            if (in_seq) begin
                cyc++;
                if (start_o) begin
                    obs.start_hi++;
                    if (obs.first_start == 0) obs.first_start = cyc;
                end
                if (start_o && !prev_start) begin
                    obs.rises++;
                    if (obs.rises == 2) obs.second_rise = cyc;
                end
                if (stop_o) begin
                    obs.stop_hi++;
                    if (obs.first_stop == 0) obs.first_stop = cyc;
                end
                if (start_o && stop_o) obs.both_hi++;
                if (done) obs.done_cnt++;
                if (prev_busy && !busy) begin
                    obs.end_cyc = cyc;
                    obs.pairs   = int'(pairs_sent);
                    in_seq      = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_seq_end", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("seq%0d_first_start", seq_n), obs.first_start, e.first_start);
                        check($sformatf("seq%0d_first_stop", seq_n), obs.first_stop, e.first_stop);
                        check($sformatf("seq%0d_start_rises", seq_n), obs.rises, e.rises);
                        check($sformatf("seq%0d_second_rise", seq_n), obs.second_rise, e.second_rise);
                        check($sformatf("seq%0d_start_hi", seq_n), obs.start_hi, e.start_hi);
                        check($sformatf("seq%0d_stop_hi", seq_n), obs.stop_hi, e.stop_hi);
                        check($sformatf("seq%0d_overlap", seq_n), obs.both_hi, e.both_hi);
                        check($sformatf("seq%0d_done_cnt", seq_n), obs.done_cnt, e.done_cnt);
                        check($sformatf("seq%0d_end_cyc", seq_n), obs.end_cyc, e.end_cyc);
                        check($sformatf("seq%0d_pairs", seq_n), obs.pairs, e.pairs);
                    end
                    seq_n++;
                end
            end
            prev_start = start_o;
            prev_busy  = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [7:0] d, input logic [3:0] w, input logic [3:0] n,
                         input seq_t e);
        cfg_valid = 1'b1;
        cfg_delay = d;
        cfg_width = w;
        cfg_count = n;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_start", start_o, 1);
        check("accept_pairs_clear", pairs_sent, 0);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        bit got_done;
        rst       = 1'b1;
        ena       = 1'b1;
        cfg_valid = 1'b0;
        cfg_delay = 8'd0;
        cfg_width = 4'd0;
        cfg_count = 4'd0;
        abort     = 1'b0;

        #1;
        check("rst_start", start_o, 0);
        check("rst_stop", stop_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pairs", pairs_sent, 0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // D=5 W=2 N=1
        issue(8'd5, 4'd2, 4'd1, mk(1, 6, 1, 0, 2, 2, 0, 1, 8, 1));
        wait_idle(40);

        // D=1 W=3 N=2: overlapping pulses, 8-cycle start spacing
        issue(8'd1, 4'd3, 4'd2, mk(1, 2, 2, 9, 6, 6, 4, 1, 13, 2));
        wait_idle(40);

        // D=0 W=0 N=0 -> D=1 W=1 N=16
        issue(8'd0, 4'd0, 4'd0, mk(1, 2, 16, 7, 16, 16, 0, 1, 93, 16));
        wait_idle(200);

        // abort during second of three pairs (D=2 W=2)
        issue(8'd2, 4'd2, 4'd3, mk(1, 3, 2, 9, 4, 2, 0, 0, 11, 1));
        repeat (9) @(posedge clk);
        #1;
        check("abort_pre_start", start_o, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        check("abort_start_low", start_o, 0);
        check("abort_stop_low", stop_o, 0);
        check("abort_busy_low", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_pairs_held", pairs_sent, 1);
        check("abort_blocks_ready", cfg_ready, 0);
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        check("abort_priority_no_accept", busy, 0);
        abort     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check("abort_ready_again", cfg_ready, 1);

        // cfg_valid held through a sequence; new values must not disturb the running one
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_delay = 8'd3;
        cfg_width = 4'd1;
        cfg_count = 4'd1;
        exp_q.push_back(mk(1, 4, 1, 0, 1, 1, 0, 1, 5, 1));
        @(posedge clk); #1;
        cfg_delay = 8'd2;
        cfg_width = 4'd2;
        cfg_count = 4'd1;
        exp_q.push_back(mk(1, 3, 1, 0, 2, 2, 0, 1, 5, 1));
        got_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                got_done = 1;
                break;
            end
        end
        check("b2b_done_seen", got_done, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_first_pulse", start_o, 1);
        wait_idle(40);

        // reset asserted mid-pulse (not scoreboarded: sequence is cut short)
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_delay = 8'd4;
        cfg_width = 4'd3;
        cfg_count = 4'd2;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_pre_start", start_o, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_start", start_o, 0);
        check("midrst_stop", stop_o, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pairs", pairs_sent, 0);

        // accept on the first edge after reset release
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_delay = 8'd1;
        cfg_width = 4'd1;
        cfg_count = 4'd1;
        exp_q.push_back(mk(1, 2, 1, 0, 1, 1, 0, 1, 3, 1));
        rst = 1'b0;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("postrst_busy", busy, 1);
        check("postrst_start", start_o, 1);
        wait_idle(40);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
